// File: rtl/pld_array.sv
// rtl/pld_array.sv - double-buffered PLD AND/OR array with register configuration bus
//
// Purpose: eight product terms over 12 inputs, four OR outputs feeding downstream
// macrocells, plus per-macrocell configuration bits. The bus writes into a shadow
// bank; a commit copies the shadow into the active bank that drives all outputs.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   pi[11:0]                product-term inputs
//   cfg_addr/wdata/we/re    configuration bus (single-cycle strobes)
//   cfg_rdata, cfg_rvalid   registered read data and its one-cycle valid pulse
//   commit                  external commit strobe
//   pending, locked         shadow-dirty flag, sticky lock flag
//   mc_in[3:0]              OR-array outputs (combinational from pi)
//   mc_coen/const/ssel/rsel/byp[3:0], mc_xorfb[7:0]  active macrocell config
module pld_array (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] pi,
  input  logic [5:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        cfg_we,
  input  logic        cfg_re,
  output logic [7:0]  cfg_rdata,
  output logic        cfg_rvalid,
  input  logic        commit,
  output logic        pending,
  output logic        locked,
  output logic [3:0]  mc_in,
  output logic [3:0]  mc_coen,
  output logic [3:0]  mc_const,
  output logic [3:0]  mc_ssel,
  output logic [3:0]  mc_rsel,
  output logic [3:0]  mc_byp,
  output logic [7:0]  mc_xorfb
);

  localparam logic [5:0] ADDR_CTRL = 6'd32;
  localparam logic [5:0] ADDR_STAT = 6'd33;

  // Shadow bank is byte-addressed exactly as the bus sees it (addr 0..31).
  logic [7:0]  shadow_q [32];

  // Active bank is kept unpacked into fields; the spare MC bit is never copied.
  logic [11:0] act_true_q [8];
  logic [11:0] act_cmp_q  [8];
  logic [7:0]  act_or_q   [4];
  logic [6:0]  act_mc_q   [4];

  logic        pending_q, pending_d;
  logic        locked_q, locked_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q;

  logic        in_bank;
  logic        ctrl_wr;
  logic        commit_now;
  logic        shadow_wr;
  logic [7:0]  rd_val;
  logic [7:0]  pt;

  assign in_bank    = ~cfg_addr[5];
  assign ctrl_wr    = cfg_we && (cfg_addr == ADDR_CTRL);
  assign commit_now = commit || (ctrl_wr && cfg_wdata[0]);
  assign shadow_wr  = cfg_we && in_bank && !locked_q;

  // A shadow write in the commit cycle leaves new data uncommitted, so it wins.
  assign pending_d = shadow_wr ? 1'b1 : (commit_now ? 1'b0 : pending_q);
  assign locked_d  = locked_q | (ctrl_wr & cfg_wdata[1]);

  always_comb begin
    rd_val = 8'h00;
    if (in_bank) begin
      rd_val = shadow_q[cfg_addr[4:0]];
    end else if (cfg_addr == ADDR_STAT) begin
      rd_val = {6'b0, locked_q, pending_q};
    end
  end

  assign rdata_d = cfg_re ? rd_val : rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h00;
    end else if (shadow_wr) begin
      shadow_q[cfg_addr[4:0]] <= cfg_wdata;
    end
  end

  // Active bank samples the pre-write shadow, so a same-cycle write stays pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 8; n++) begin
        act_true_q[n] <= 12'h000;
        act_cmp_q[n]  <= 12'h000;
      end
      for (int m = 0; m < 4; m++) begin
        act_or_q[m] <= 8'h00;
        act_mc_q[m] <= 7'h00;
      end
    end else if (commit_now) begin
      for (int n = 0; n < 8; n++) begin
        act_true_q[n] <= {shadow_q[3*n+1][3:0], shadow_q[3*n]};
        act_cmp_q[n]  <= {shadow_q[3*n+2], shadow_q[3*n+1][7:4]};
      end
      for (int m = 0; m < 4; m++) begin
        act_or_q[m] <= shadow_q[24+m];
        act_mc_q[m] <= shadow_q[28+m][6:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 1'b0;
      locked_q  <= 1'b0;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      locked_q  <= locked_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= cfg_re;
    end
  end

  // An empty term would reduce to AND of nothing (=1); force it to 0 instead.
  always_comb begin
    pt = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if ((|act_true_q[n]) || (|act_cmp_q[n])) begin
        pt[n] = &((~act_true_q[n] | pi) & (~act_cmp_q[n] | ~pi));
      end
    end
  end

  always_comb begin
    mc_in = 4'h0;
    for (int m = 0; m < 4; m++) begin
      mc_in[m] = |(pt & act_or_q[m]);
    end
  end

  always_comb begin
    mc_coen  = 4'h0;
    mc_const = 4'h0;
    mc_ssel  = 4'h0;
    mc_rsel  = 4'h0;
    mc_byp   = 4'h0;
    mc_xorfb = 8'h00;
    for (int m = 0; m < 4; m++) begin
      mc_coen[m]         = act_mc_q[m][0];
      mc_const[m]        = act_mc_q[m][1];
      mc_xorfb[2*m +: 2] = act_mc_q[m][3:2];
      mc_ssel[m]         = act_mc_q[m][4];
      mc_rsel[m]         = act_mc_q[m][5];
      mc_byp[m]          = act_mc_q[m][6];
    end
  end

  assign pending    = pending_q;
  assign locked     = locked_q;
  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;

endmodule
